mchan_cmd_arbiter_ipa: RTL and testbench

//  Round-robin arbiter sharing one 2D transfer splitter between NB_REQ command queues (cluster cores / HWPE ports).

---
 rtl/mchan_ipa_arb_pkg.sv | 39 +++
 rtl/mchan_cmd_arbiter_ipa_picker.sv | 46 ++++
 rtl/mchan_cmd_arbiter_ipa.sv | 137 +++++++++++++
 tb/tb_mchan_cmd_arbiter_ipa.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mchan_ipa_arb_pkg.sv
// ----------------------------------------------------------------------------
// Package: mchan_ipa_arb_pkg
// Purpose: Shared types for the MCHAN command arbiter slice.
//   - Field widths of a DMA command (stand-ins for the mchan_ipa_defines values).
//   - mchan_cmd_t : packed command record carried from the core queues to the
//                   2D transfer splitter.
//   - arb_state_e : occupancy state of the arbiter's one-entry output register.
// Ports: none (package).
// ----------------------------------------------------------------------------
package mchan_ipa_arb_pkg;

   localparam int TRANS_SID_WIDTH  = 1;
   localparam int MCHAN_OPC_WIDTH  = 4;
   localparam int MCHAN_LEN_WIDTH  = 16;
   localparam int TWD_COUNT_WIDTH  = 16;
   localparam int TWD_STRIDE_WIDTH = 16;
   localparam int TCDM_ADD_WIDTH   = 12;
   localparam int EXT_ADD_WIDTH    = 29;

   // One DMA command exactly as queued by a core; the arbiter never
   // reinterprets these fields, it only moves them.
   typedef struct packed {
      logic [TRANS_SID_WIDTH-1:0]  sid;
      logic [MCHAN_OPC_WIDTH-1:0]  opc;
      logic [MCHAN_LEN_WIDTH-1:0]  len;
      logic                        inc;
      logic                        twd;
      logic [TWD_COUNT_WIDTH-1:0]  count;
      logic [TWD_STRIDE_WIDTH-1:0] stride;
      logic [TCDM_ADD_WIDTH-1:0]   tcdm_add;
      logic [EXT_ADD_WIDTH-1:0]    ext_add;
   } mchan_cmd_t;

   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_FULL  = 1'b1
   } arb_state_e;

endpackage : mchan_ipa_arb_pkg

// File: rtl/mchan_cmd_arbiter_ipa_picker.sv
// ----------------------------------------------------------------------------
// Module: mchan_rr_picker_ipa
// Purpose: Combinational round-robin winner search. Returns the first set bit
//          of req_i found by scanning upward from ptr_i+1, wrapping from
//          NB_REQ-1 back to 0.
// Ports:
//   req_i   in  NB_REQ      request mask to search
//   ptr_i   in  SRC_WIDTH   index of the last winner (search starts above it)
//   idx_o   out SRC_WIDTH   index of the winner
//   valid_o out 1           at least one request was set
// ----------------------------------------------------------------------------
module mchan_rr_picker_ipa #(
   parameter int NB_REQ    = 4,
   parameter int SRC_WIDTH = $clog2(NB_REQ)
) (
   input  logic [NB_REQ-1:0]    req_i,
   input  logic [SRC_WIDTH-1:0] ptr_i,
   output logic [SRC_WIDTH-1:0] idx_o,
   output logic                 valid_o
);

   logic [2*NB_REQ-1:0] dblReq;
   logic [2*NB_REQ-1:0] dblMasked;

   // Two copies of the mask side by side turn the wrapping search into a plain
   // lowest-bit search: clearing everything at or below ptr leaves the upper
   // part of the first copy followed by the whole second copy, which is
   // exactly the order ptr+1 .. ptr+NB_REQ. The downward loop makes the
   // lowest surviving bit the last assignment, so it wins.
   always_comb begin
      dblReq    = {req_i, req_i};
      dblMasked = '0;
      valid_o   = 1'b0;
      idx_o     = '0;
      for (int i = 0; i < 2*NB_REQ; i++) begin
         dblMasked[i] = dblReq[i] & (i > int'(ptr_i));
      end
      for (int i = 2*NB_REQ-1; i >= 0; i--) begin
         if (dblMasked[i]) begin
            valid_o = 1'b1;
            idx_o   = SRC_WIDTH'(i % NB_REQ);
         end
      end
   end

endmodule : mchan_rr_picker_ipa

// File: rtl/mchan_cmd_arbiter_ipa.sv
// ----------------------------------------------------------------------------
// Module: mchan_cmd_arbiter_ipa
// Purpose: Round-robin arbiter sharing one 2D transfer splitter between NB_REQ
//          command queues. One pending command per cycle is granted and
//          latched into a one-entry output register presented on the splitter
//          req/gnt handshake together with the winning requester index.
// Optional feature: `define MCHAN_ARB_PRIO_EN to give requesters flagged in
//          prio_i precedence (round-robin inside that class first, same
//          pointer). Without it prio_i is ignored.
// Ports:
//   clk_i      in  1                  clock
//   rst_ni     in  1                  synchronous reset, active-low
//   req_i      in  NB_REQ             per-requester command valid
//   gnt_o      out NB_REQ             per-requester grant (one-hot or zero)
//   cmd_i      in  NB_REQ x mchan_cmd_t per-requester command
//   prio_i     in  NB_REQ             high-priority flags
//   out_req_o  out 1                  command valid to splitter
//   out_gnt_i  in  1                  splitter accept
//   out_cmd_o  out mchan_cmd_t        latched command
//   out_src_o  out SRC_WIDTH          requester owning out_cmd_o
//   busy_o     out 1                  output register occupied
// ----------------------------------------------------------------------------
module mchan_cmd_arbiter_ipa
   import mchan_ipa_arb_pkg::*;
#(
   parameter  int NB_REQ    = 4,
   localparam int SRC_WIDTH = $clog2(NB_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NB_REQ-1:0]    req_i,
   output logic [NB_REQ-1:0]    gnt_o,
   input  mchan_cmd_t           cmd_i [NB_REQ],
   input  logic [NB_REQ-1:0]    prio_i,
   output logic                 out_req_o,
   input  logic                 out_gnt_i,
   output mchan_cmd_t           out_cmd_o,
   output logic [SRC_WIDTH-1:0] out_src_o,
   output logic                 busy_o
);

   arb_state_e           state_q;
   logic                 outReq_q;
   mchan_cmd_t           outCmd_q;
   logic [SRC_WIDTH-1:0] outSrc_q;
   logic [SRC_WIDTH-1:0] ptr_q;
   logic [SRC_WIDTH-1:0] ptr_d;

   logic [SRC_WIDTH-1:0] winIdx;
   logic                 winValid;
   logic                 canLoad;
   logic                 grant;

`ifdef MCHAN_ARB_PRIO_EN
   logic [SRC_WIDTH-1:0] prioIdx;
   logic                 prioValid;
   logic [SRC_WIDTH-1:0] normIdx;
   logic                 normValid;

   mchan_rr_picker_ipa #(.NB_REQ(NB_REQ), .SRC_WIDTH(SRC_WIDTH)) prioPicker (
      .req_i   (req_i & prio_i),
      .ptr_i   (ptr_q),
      .idx_o   (prioIdx),
      .valid_o (prioValid)
   );

   mchan_rr_picker_ipa #(.NB_REQ(NB_REQ), .SRC_WIDTH(SRC_WIDTH)) normPicker (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .idx_o   (normIdx),
      .valid_o (normValid)
   );

   // High-priority requesters win whenever any of them is pending; both
   // classes advance the same pointer so neither class loses its rotation.
   assign winIdx   = prioValid ? prioIdx : normIdx;
   assign winValid = prioValid | normValid;
`else
   logic unusedPrio;
   assign unusedPrio = ^prio_i;

   mchan_rr_picker_ipa #(.NB_REQ(NB_REQ), .SRC_WIDTH(SRC_WIDTH)) normPicker (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .idx_o   (winIdx),
      .valid_o (winValid)
   );
`endif

   // The output slot can take a new command when it is empty or when the
   // splitter is consuming the current one this very cycle, which gives one
   // command per cycle with no bubble.
   assign canLoad = (state_q == ARB_EMPTY) | out_gnt_i;
   assign grant   = canLoad & winValid;
   assign ptr_d   = grant ? winIdx : ptr_q;

   // Grants are combinational so a queue sees acceptance in the same cycle it
   // asks; they are held low during reset so no queue pops a command that the
   // reset is about to throw away.
   always_comb begin
      gnt_o = '0;
      if (rst_ni && grant) begin
         gnt_o[winIdx] = 1'b1;
      end
   end

   // Output slot FSM. A grant always refills the slot (even while the splitter
   // takes the previous command); the slot only empties when the splitter
   // accepts and nothing new is granted. The pointer resets to NB_REQ-1 so the
   // first search starts at requester 0.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ARB_EMPTY;
         outReq_q <= 1'b0;
         outCmd_q <= '0;
         outSrc_q <= '0;
         ptr_q    <= SRC_WIDTH'(NB_REQ - 1);
      end else begin
         ptr_q <= ptr_d;
         if (grant) begin
            state_q  <= ARB_FULL;
            outReq_q <= 1'b1;
            outCmd_q <= cmd_i[winIdx];
            outSrc_q <= winIdx;
         end else if ((state_q == ARB_FULL) && out_gnt_i) begin
            state_q  <= ARB_EMPTY;
            outReq_q <= 1'b0;
         end
      end
   end

   assign out_req_o = outReq_q;
   assign busy_o    = outReq_q;
   assign out_cmd_o = outCmd_q;
   assign out_src_o = outSrc_q;

endmodule : mchan_cmd_arbiter_ipa

// File: tb/tb_mchan_cmd_arbiter_ipa.sv
// ----------------------------------------------------------------------------
// Testbench: tb_mchan_cmd_arbiter_ipa
// Purpose: Directed scenarios plus a randomized run of mchan_cmd_arbiter_ipa,
//          checked against a behavioural model of the arbitration rules.
//          Scenario for the priority feature is compiled in only when
//          MCHAN_ARB_PRIO_EN is defined.
// ----------------------------------------------------------------------------
module tb_mchan_cmd_arbiter_ipa;
   import mchan_ipa_arb_pkg::*;

   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rstN;
   logic [NB-1:0] reqIn;
   logic [NB-1:0] gntOut;
   mchan_cmd_t    cmdIn [NB];
   logic [NB-1:0] prioIn;
   logic          outReqOut;
   logic          outGntIn;
   mchan_cmd_t    outCmdOut;
   logic [1:0]    outSrcOut;
   logic          busyOut;

   int checks   = 0;
   int failures = 0;

   // Reference model: slot occupancy, held command/owner, last winner.
   logic          mFull;
   mchan_cmd_t    mCmd;
   int            mSrc;
   int            mPtr;
   logic [NB-1:0] expGnt;

   mchan_cmd_arbiter_ipa #(.NB_REQ(NB)) dut (
      .clk_i     (clk),
      .rst_ni    (rstN),
      .req_i     (reqIn),
      .gnt_o     (gntOut),
      .cmd_i     (cmdIn),
      .prio_i    (prioIn),
      .out_req_o (outReqOut),
      .out_gnt_i (outGntIn),
      .out_cmd_o (outCmdOut),
      .out_src_o (outSrcOut),
      .busy_o    (busyOut)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Winner by the arbitration rule: scan ptr+1, ptr+2, ... modulo NB over the
   // priority set if it is non-empty (feature builds), else over all requests.
   function automatic int refWinner(logic [NB-1:0] req, logic [NB-1:0] prio, int ptr);
      logic [NB-1:0] m;
      m = req;
`ifdef MCHAN_ARB_PRIO_EN
      if ((req & prio) != '0) m = req & prio;
`else
      if (prio != prio) m = '0;
`endif
      for (int s = 1; s <= NB; s++) begin
         if (m[(ptr + s) % NB]) return (ptr + s) % NB;
      end
      return -1;
   endfunction

   // Drives one cycle of inputs on the falling edge with fresh random commands
   // and predicts the combinational grant for that cycle.
   task automatic applyStimulus(input logic [NB-1:0] req, input logic og, input logic [NB-1:0] prio);
      logic [127:0] r;
      int w;
      @(negedge clk);
      reqIn    = req;
      outGntIn = og;
      prioIn   = prio;
      for (int k = 0; k < NB; k++) begin
         r = {$urandom(), $urandom(), $urandom(), $urandom()};
         cmdIn[k] = r[$bits(mchan_cmd_t)-1:0];
      end
      #1;
      w = refWinner(reqIn, prioIn, mPtr);
      expGnt = '0;
      if (rstN && (!mFull || og) && w >= 0) expGnt[w] = 1'b1;
   endtask

   // Advances the model across the rising edge, then settles past it.
   task automatic advance();
      int w;
      @(posedge clk);
      if (!rstN) begin
         mFull = 1'b0;
         mCmd  = '0;
         mSrc  = 0;
         mPtr  = NB - 1;
      end else begin
         w = refWinner(reqIn, prioIn, mPtr);
         if ((!mFull || outGntIn) && w >= 0) begin
            mFull = 1'b1;
            mCmd  = cmdIn[w];
            mSrc  = w;
            mPtr  = w;
         end else if (mFull && outGntIn) begin
            mFull = 1'b0;
         end
      end
      #1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      applyStimulus('0, 1'b0, '0);
      advance();
      rstN = 1'b1;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      applyStimulus(4'b1111, 1'b1, '0);
      checks++;
      if (gntOut !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_gnt got=%b want=0000", gntOut);
      end
      advance();
      checks++;
      if (outReqOut !== 1'b0 || busyOut !== 1'b0 || outSrcOut !== 2'd0 || outCmdOut !== mchan_cmd_t'('0)) begin
         failures++;
         $display("[TB] FAIL reset_state got req=%b busy=%b src=%0d cmd=%h want all zero",
                  outReqOut, busyOut, outSrcOut, outCmdOut);
      end
      rstN = 1'b1;
   endtask

   task automatic test_round_robin();
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 1'b1, '0);
         checks++;
         if (gntOut !== 4'(1 << (i % NB)) || gntOut !== expGnt) begin
            failures++;
            $display("[TB] FAIL rr_gnt cycle=%0d got=%b want=%b", i, gntOut, 4'(1 << (i % NB)));
         end
         advance();
         checks++;
         if (outReqOut !== 1'b1 || outSrcOut !== 2'(i % NB) || outCmdOut !== mCmd) begin
            failures++;
            $display("[TB] FAIL rr_out cycle=%0d got req=%b src=%0d want req=1 src=%0d",
                     i, outReqOut, outSrcOut, i % NB);
         end
      end
   endtask

   task automatic test_single_requester();
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0100, 1'b1, '0);
         checks++;
         if (gntOut !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL single_gnt cycle=%0d got=%b want=0100", i, gntOut);
         end
         advance();
         checks++;
         if (outReqOut !== 1'b1 || outSrcOut !== 2'd2 || outCmdOut !== mCmd) begin
            failures++;
            $display("[TB] FAIL single_out cycle=%0d got req=%b src=%0d cmd=%h want req=1 src=2 cmd=%h",
                     i, outReqOut, outSrcOut, outCmdOut, mCmd);
         end
      end
   endtask

   task automatic test_stall();
      mchan_cmd_t held;
      doReset();
      applyStimulus(4'b0010, 1'b0, '0);
      checks++;
      if (gntOut !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL stall_load got=%b want=0010", gntOut);
      end
      advance();
      held = cmdIn[1];
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 1'b0, '0);
         checks++;
         if (gntOut !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL stall_gnt cycle=%0d got=%b want=0000", i, gntOut);
         end
         advance();
         checks++;
         if (outReqOut !== 1'b1 || outSrcOut !== 2'd1 || outCmdOut !== held) begin
            failures++;
            $display("[TB] FAIL stall_hold cycle=%0d got req=%b src=%0d cmd=%h want req=1 src=1 cmd=%h",
                     i, outReqOut, outSrcOut, outCmdOut, held);
         end
      end
      applyStimulus(4'b1111, 1'b1, '0);
      checks++;
      if (gntOut !== 4'b0100) begin
         failures++;
         $display("[TB] FAIL stall_resume got=%b want=0100", gntOut);
      end
      advance();
   endtask

   task automatic test_dropped_request();
      doReset();
      applyStimulus(4'b0001, 1'b0, '0);
      advance();
      applyStimulus(4'b1000, 1'b0, '0);
      checks++;
      if (gntOut !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL drop_gnt got=%b want=0000", gntOut);
      end
      advance();
      applyStimulus(4'b0000, 1'b1, '0);
      advance();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0000, 1'b1, '0);
         checks++;
         if (gntOut !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL drop_idle_gnt cycle=%0d got=%b want=0000", i, gntOut);
         end
         advance();
         checks++;
         if (outReqOut !== 1'b0 || busyOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drop_idle cycle=%0d got req=%b busy=%b want 0", i, outReqOut, busyOut);
         end
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      applyStimulus(4'b0100, 1'b0, '0);
      cmdIn[2].len = 16'h003F;
      advance();
      checks++;
      if (outReqOut !== 1'b1 || outCmdOut.len !== 16'h003F) begin
         failures++;
         $display("[TB] FAIL midreset_load got req=%b len=%h want req=1 len=003f", outReqOut, outCmdOut.len);
      end
      rstN = 1'b0;
      applyStimulus(4'b1111, 1'b0, '0);
      checks++;
      if (gntOut !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL midreset_gnt got=%b want=0000", gntOut);
      end
      advance();
      checks++;
      if (outReqOut !== 1'b0 || outCmdOut !== mchan_cmd_t'('0)) begin
         failures++;
         $display("[TB] FAIL midreset_clear got req=%b cmd=%h want 0", outReqOut, outCmdOut);
      end
      rstN = 1'b1;
      applyStimulus(4'b1111, 1'b1, '0);
      checks++;
      if (gntOut !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL midreset_next got=%b want=0001", gntOut);
      end
      advance();
   endtask

`ifdef MCHAN_ARB_PRIO_EN
   task automatic test_priority();
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b1111, 1'b1, 4'b1000);
         checks++;
         if (gntOut !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL prio_gnt cycle=%0d got=%b want=1000", i, gntOut);
         end
         advance();
      end
      applyStimulus(4'b1111, 1'b1, 4'b0000);
      checks++;
      if (gntOut !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL prio_release got=%b want=0001", gntOut);
      end
      advance();
   endtask
`endif

   task automatic test_random();
      logic [NB-1:0] prio;
      doReset();
      for (int i = 0; i < 400; i++) begin
         prio = '0;
`ifdef MCHAN_ARB_PRIO_EN
         prio = NB'($urandom_range(0, 15)) & NB'($urandom_range(0, 15));
`endif
         applyStimulus(NB'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), prio);
         checks++;
         if (gntOut !== expGnt) begin
            failures++;
            $display("[TB] FAIL rand_gnt cycle=%0d got=%b want=%b", i, gntOut, expGnt);
         end
         advance();
         checks++;
         if (outReqOut !== mFull || busyOut !== mFull ||
             (mFull && (outSrcOut !== 2'(mSrc) || outCmdOut !== mCmd))) begin
            failures++;
            $display("[TB] FAIL rand_out cycle=%0d got req=%b busy=%b src=%0d want req=%b src=%0d",
                     i, outReqOut, busyOut, outSrcOut, mFull, mSrc);
         end
      end
   endtask

   // Scenario sequence; each scenario starts from its own reset.
   initial begin
      rstN     = 1'b0;
      reqIn    = '0;
      prioIn   = '0;
      outGntIn = 1'b0;
      mFull    = 1'b0;
      mCmd     = '0;
      mSrc     = 0;
      mPtr     = NB - 1;
      expGnt   = '0;
      for (int k = 0; k < NB; k++) cmdIn[k] = '0;
      test_reset();
      test_round_robin();
      test_single_requester();
      test_stall();
      test_dropped_request();
      test_reset_mid();
`ifdef MCHAN_ARB_PRIO_EN
      test_priority();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mchan_cmd_arbiter_ipa
